// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared FSM encodings and frame constants for the serial program loader.
package serial_loader_pkg;
   localparam int HDR_W = 16;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and start-glitch rejection.
module uart_rx_core
   import serial_loader_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] byte_data,
   output logic                 byte_valid,
   output logic                 stop_err
);
   localparam int CW = $clog2(CLK_DIV);
   rx_state_t st;
   logic [1:0] sync;
   logic prev;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st <= RX_IDLE;
         sync <= 2'b11;
         prev <= 1'b1;
         cnt <= '0;
         idx <= '0;
         byte_data <= '0;
         byte_valid <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         sync <= {sync[0], rx};
         prev <= sync[1];
         byte_valid <= 1'b0;
         stop_err <= 1'b0;
         if (st != RX_IDLE && cnt != '0) cnt <= cnt - 1'b1;
         else case (st)
            // edge is seen one clock late, so the wait is shortened by one to land mid start bit
            RX_IDLE: if (prev && !sync[1]) begin
               st <= RX_START;
               cnt <= CW'(CLK_DIV / 2 - 2);
            end
            RX_START: begin
               st <= sync[1] ? RX_IDLE : RX_BITS;
               cnt <= CW'(CLK_DIV - 1);
               idx <= '0;
            end
            RX_BITS: begin
               cnt <= CW'(CLK_DIV - 1);
               idx <= idx + 1'b1;
               if (idx < 4'(DATA_BITS)) byte_data <= {sync[1], byte_data[DATA_BITS-1:1]};
               else if (!sync[1]) begin
                  stop_err <= 1'b1;
                  st <= RX_IDLE;
               end else if (idx == 4'(DATA_BITS + STOP_BITS - 1)) begin
                  byte_valid <= 1'b1;
                  st <= RX_IDLE;
               end
            end
            default: st <= RX_IDLE;
         endcase
      end
endmodule

// File: rtl/serial_loader.sv
// serial_loader: UART program loader writing little-endian 32-bit words into word-addressed RAM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module serial_loader
   import serial_loader_pkg::*;
#(
   parameter int CLK_DIV = 434,
   parameter int D_DEPTH_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   input  logic                     start,
   output logic                     mem_en,
   output logic [3:0]               mem_we_mask,
   output logic [D_DEPTH_WIDTH-1:0] mem_addr,
   output logic [31:0]              mem_data,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     frame_err
);
   state_t state;
   logic [7:0] byte_data, bd_q;
   logic byte_valid, stop_err, bv_q, se_q;
   logic [HDR_W-1:0] n, len;
   logic [D_DEPTH_WIDTH-1:0] idx;
   logic [1:0] byte_cnt;
   logic [23:0] lanes;
   logic last, to_end;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif
   uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .byte_data(byte_data),
      .byte_valid(byte_valid),
      .stop_err(stop_err)
   );
   assign len = {bd_q, n[7:0]};
   assign last = 32'(idx) == 32'(n) - 32'd1;
   // image complete: empty header, or fourth byte of the final word
   assign to_end = bv_q && ((state == HDR_HI && len == '0) || (state == DATA && byte_cnt == 2'd3 && last));
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         bd_q <= '0;
         bv_q <= 1'b0;
         se_q <= 1'b0;
         n <= '0;
         idx <= '0;
         byte_cnt <= '0;
         lanes <= '0;
         mem_en <= 1'b0;
         mem_we_mask <= 4'h0;
         mem_addr <= '0;
         mem_data <= '0;
         cpu_hold <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum <= '0;
`endif
      end else begin
         bd_q <= byte_data;
         bv_q <= byte_valid;
         se_q <= stop_err;
         mem_en <= 1'b0;
         mem_we_mask <= 4'h0;
         case (state)
            IDLE, DONE, ERROR: if (start) begin
               done <= 1'b0;
               frame_err <= 1'b0;
               idx <= '0;
               byte_cnt <= '0;
               cpu_hold <= 1'b1;
               busy <= 1'b1;
               state <= HDR_LO;
`ifdef LOADER_CHECKSUM_EN
               csum <= '0;
`endif
            end
            HDR_LO: if (bv_q) begin
               n[7:0] <= bd_q;
               state <= HDR_HI;
            end
            HDR_HI: if (bv_q) begin
               n <= len;
               if (32'(len) > (32'd1 << D_DEPTH_WIDTH)) begin
                  state <= ERROR;
                  frame_err <= 1'b1;
                  busy <= 1'b0;
               end else state <= DATA;
            end
            DATA: if (bv_q) begin
               byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               csum <= csum ^ bd_q;
`endif
               if (byte_cnt != 2'd3) lanes[{byte_cnt, 3'b000} +: 8] <= bd_q;
               else begin
                  mem_en <= 1'b1;
                  mem_we_mask <= 4'hF;
                  mem_addr <= idx;
                  mem_data <= {bd_q, lanes};
                  if (!last) idx <= idx + 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: if (bv_q) begin
               busy <= 1'b0;
               if (bd_q == csum) begin
                  state <= DONE;
                  done <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  state <= ERROR;
                  frame_err <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
         if (to_end) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            cpu_hold <= 1'b0;
`endif
         end
         if (se_q && busy) begin
            state <= ERROR;
            frame_err <= 1'b1;
            busy <= 1'b0;
         end
      end
endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed and randomized loads checked against a word-image reference model.
module tb_serial_loader;
   localparam int CD = 4;
   localparam int DW = 10;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, rx = 1'b1, start = 1'b0;
   logic mem_en, cpu_hold, busy, done, frame_err;
   logic [3:0] mem_we_mask;
   logic [DW-1:0] mem_addr;
   logic [31:0] mem_data;
   int tests = 0, fails = 0, wcount = 0;
   logic [DW-1:0] wr_addr [64];
   logic [31:0] wr_data [64];
   logic [3:0] wr_mask [64];
   logic wr_done [64];
   logic [31:0] exp_words [$];

   always #5 clk = ~clk;

   serial_loader #(.CLK_DIV(CD), .D_DEPTH_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .rx(rx), .start(start),
      .mem_en(mem_en), .mem_we_mask(mem_we_mask), .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .frame_err(frame_err)
   );

   always @(negedge clk)
      if (mem_en && wcount < 64) begin
         wr_addr[wcount] = mem_addr;
         wr_data[wcount] = mem_data;
         wr_mask[wcount] = mem_we_mask;
         wr_done[wcount] = done;
         wcount++;
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CD) @(negedge clk);
      end
      rx = stop;
      repeat (CD) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CD) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int k;
      k = 0;
      while (!(done || frame_err) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " timeout"}, 32'(k < 2000), 32'd1);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      chk({tag, " rst data"}, mem_data, 32'd0);
      chk({tag, " rst ctl"}, 32'({mem_en, mem_we_mask, mem_addr, cpu_hold, busy, done, frame_err}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [7:0] csum_of();
      logic [7:0] x = 8'h00;
      foreach (exp_words[k]) x ^= exp_words[k][7:0] ^ exp_words[k][15:8] ^ exp_words[k][23:16] ^ exp_words[k][31:24];
      return x;
   endfunction

   // full load of exp_words; the model is simply "word k lands at address k"
   task automatic do_load(input string tag, input bit glitch);
      int n;
      n = exp_words.size();
      wcount = 0;
      pulse_start();
      chk({tag, " hold/busy"}, 32'({cpu_hold, busy}), 32'd3);
      if (glitch) begin
         rx = 1'b0;
         @(negedge clk) rx = 1'b1;
         repeat (5 * CD) @(negedge clk);
      end
      send_byte(n[7:0], 1'b1);
      send_byte(n[15:8], 1'b1);
      foreach (exp_words[k])
         for (int j = 0; j < 4; j++) send_byte(exp_words[k][8*j +: 8], 1'b1);
      if (CS) send_byte(csum_of(), 1'b1);
      wait_end(tag);
      chk({tag, " flags"}, 32'({done, cpu_hold, busy, frame_err}), 32'b1000);
      chk({tag, " count"}, 32'(wcount), 32'(n));
      foreach (exp_words[k]) begin
         chk({tag, " addr"}, 32'(wr_addr[k]), 32'(k));
         chk({tag, " data"}, wr_data[k], exp_words[k]);
         chk({tag, " mask"}, 32'(wr_mask[k]), 32'hF);
      end
      if (n > 0) chk({tag, " done@last"}, 32'(wr_done[n-1]), 32'(!CS));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset("init");

      exp_words = '{32'h12345678, 32'hDEADBEEF};
      do_load("basic", 1'b0);

      for (int r = 0; r < 4; r++) begin
         int n;
         exp_words.delete();
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) exp_words.push_back($urandom);
         do_load("rand", r == 2);
      end

      exp_words.delete();
      do_load("zero", 1'b0);

      exp_words = '{32'hCAFEF00D};
      do_load("glitch", 1'b1);

      wcount = 0;
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h04, 1'b1);
      wait_end("oversize");
      chk("oversize flags", 32'({done, cpu_hold, busy, frame_err}), 32'b0101);
      chk("oversize writes", 32'(wcount), 32'd0);

      pulse_start();
      chk("max clears err", 32'(frame_err), 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1);
      repeat (10) @(negedge clk);
      chk("max accepted", 32'({busy, frame_err, cpu_hold}), 32'b101);
      apply_reset("max");

      wcount = 0;
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b0);
      wait_end("frame");
      chk("frame flags", 32'({done, cpu_hold, busy, frame_err}), 32'b0101);
      repeat (20) @(negedge clk);
      chk("frame writes", 32'(wcount), 32'd0);
      pulse_start();
      chk("frame restart", 32'({frame_err, busy}), 32'b01);
      apply_reset("frame");

      wcount = 0;
      pulse_start();
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h88, 1'b1);
      send_byte(8'h77, 1'b1);
      apply_reset("mid");
      chk("mid writes", 32'(wcount), 32'd1);
      chk("mid word0", wr_data[0], 32'h11223344);

`ifdef LOADER_CHECKSUM_EN
      exp_words = '{32'h08040201};
      chk("csum model", 32'(csum_of()), 32'h0F);
      do_load("csum ok", 1'b0);
      wcount = 0;
      pulse_start();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h08, 1'b1);
      send_byte(8'h0E, 1'b1);
      wait_end("csum bad");
      chk("csum bad flags", 32'({done, cpu_hold, busy, frame_err}), 32'b0101);
      chk("csum bad writes", 32'(wcount), 32'd1);
      chk("csum bad word", wr_data[0], 32'h08040201);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_loader.md
# serial_loader

Bit-serial program loader: receives an 8N1 UART byte stream, assembles little-endian 32-bit words and writes them into the system's word-addressed BlockRAM. It is the writer for the memory image that the control unit later fetches. It holds the CPU in reset until the image is complete. It sits beside the CPU and drives the memory port while `cpu_hold` is asserted; the top level muxes this port onto the memory address, data and mask buses.

## Interface
- `CLK_DIV`, default 434: clocks per UART bit; must be ≥ 4.
- `D_DEPTH_WIDTH`, default 10: memory word-address width; maximum image is 2^D_DEPTH_WIDTH words.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  UART line; asynchronous input, idle high.
- `start`  in  1  one-cycle pulse that begins a load.
- `mem_en`  out  1  memory write strobe, one cycle per word.
- `mem_we_mask`  out  4  byte write mask; `4'hF` when `mem_en`=1, otherwise 0.
- `mem_addr`  out  D_DEPTH_WIDTH  word address.
- `mem_data`  out  32  assembled word.
- `cpu_hold`  out  1  hold the control unit in reset.
- `busy`  out  1  load in progress.
- `done`  out  1  image loaded successfully; sticky.
- `frame_err`  out  1  stop bit error, or length header out of range; sticky.

## Operation
- Stream format: length `N` as 2 bytes, low byte first. Then `4*N` data bytes; each word is sent least significant byte first. Word `k` is written to address `k`.
- States are IDLE, HDR_LO, HDR_HI, DATA, DONE and ERROR (plus CSUM when configured).
- IDLE, DONE, ERROR: a `start` pulse clears `done`, `frame_err`, the word index and the byte counter. It then sets `cpu_hold`=1 and `busy`=1, and moves to HDR_LO. In all other states `start` is ignored.
- HDR_LO → HDR_HI → DATA as each byte arrives.
- If `N`=0, go directly to DONE.
- If `N` > 2^D_DEPTH_WIDTH, go to ERROR and set `frame_err`. No writes occur.
- DATA: each received byte goes into byte lane `byte_cnt`. After lane 3, issue a one-cycle write and increment the word index. After word `N-1`, move to DONE.
- DONE: `busy`=0, `done`=1, `cpu_hold`=0.
- ERROR: `busy`=0, `frame_err`=1, `cpu_hold` stays 1.
- UART receiver:
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - A falling edge arms the start-bit check at `CLK_DIV/2` (integer division).
  - If the line is still low at that point, 8 data bits are sampled LSB first, each `CLK_DIV` clocks apart, followed by the stop bit.
  - If the line is high at the start-bit check, the edge is a glitch: the receiver returns to idle and no byte is emitted.
  - A stop bit sampled low raises `frame_err` and sends the FSM to ERROR. The byte is discarded.
- Bytes arriving in IDLE, DONE or ERROR are received and discarded.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- The byte-valid strobe fires in the cycle of the stop-bit sample.
- The FSM consumes the byte in the next cycle.
- For the 4th byte of a word, `mem_en`, `mem_addr` and `mem_data` are valid in the cycle after the byte is consumed. They are held for exactly one cycle.
- `done` rises in the same cycle as the final word's `mem_en`.
- `cpu_hold` rises in the cycle after `start` and falls together with `done` rising.
- Reset asserted mid-load: immediate return to reset values. A partial image is left in memory, and no write is issued.
- The word index never wraps; the maximum address is `N-1`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the final word the FSM enters CSUM and receives one extra byte.
  - That byte must equal the XOR of all `4*N` data bytes; the header bytes are not included.
  - Match: go to DONE.
  - Mismatch: go to ERROR with `frame_err`=1. The words are already written; `cpu_hold` stays 1.
  - With `N`=0 the checksum byte is still expected and must be `8'h00`.
- Undefined: there is no CSUM state, and DONE follows the last word directly.

## Structure
- Shared package holds:
  - the FSM state encoding;
  - the header width constant (16);
  - the UART frame constants (8 data bits, 1 stop bit).
- Sub-module `uart_rx_core` contains the synchroniser, baud counter and bit shifter. It outputs `byte_data[7:0]`, `byte_valid` and `stop_err`.
- The top level holds the loader FSM, byte lane register, word index and optional checksum.

## Test plan
All scenarios use `CLK_DIV`=4.
- Basic load: send `start`, then the stream `02 00 | 78 56 34 12 | EF BE AD DE`. Required: two writes, addr 0 = `32'h12345678` and addr 1 = `32'hDEADBEEF`, each with mask `F`. Then `done`=1, `cpu_hold`=0 and `busy`=0.
- Zero length: header `00 00` → no `mem_en`; `done` is asserted after the second header byte. With `LOADER_CHECKSUM_EN`, send `00` → `done`=1.
- Oversize header: header `01 04` (N=1025) → ERROR with `frame_err`=1, no writes, and `cpu_hold`=1.
- Framing error: the 3rd data byte is sent with stop bit 0 → `frame_err`=1 and no `mem_en` for that word. A following `start` clears `frame_err`.
- Glitch plus reset: a 1-clock low pulse on `rx` produces no byte. Asserting `rst` between the 2nd and 3rd bytes of a word returns all outputs to 0 with no write.
- Checksum (macro defined): `01 00 01 02 04 08` followed by `0F` → `done`=1. Followed by `0E` instead → `frame_err`=1, and addr 0 still holds `32'h08040201`.
